// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
//   CLA_WIDTH_DEF / CLA_GROUP_DEF : default operand width and lookahead group size
//   MODE_ADD / MODE_SUB           : encodings of the mode input
package cla_pkg;

   localparam int unsigned CLA_WIDTH_DEF = 16;
   localparam int unsigned CLA_GROUP_DEF = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: group propagate/generate plus per-bit sum.
//   p_i  : bitwise propagate terms of the group
//   g_i  : bitwise generate terms of the group
//   ci_i : carry into the group's LSB
//   gp_o : group propagate (AND of all p)
//   gg_o : group generate
//   s_o  : per-bit sum using carries derived from ci_i
module cla_group #(
   parameter int unsigned GROUP = 4
) (
   input  logic [GROUP-1:0] p_i,
   input  logic [GROUP-1:0] g_i,
   input  logic             ci_i,
   output logic             gp_o,
   output logic             gg_o,
   output logic [GROUP-1:0] s_o
);

   // Group P/G depend only on p/g; kept apart from the sum so the carry-in
   // path never appears to loop back into them.
   always_comb begin
      gp_o = 1'b1;
      gg_o = 1'b0;
      for (int unsigned i = 0; i < GROUP; i++) begin
         gg_o = g_i[i] | (p_i[i] & gg_o);
         gp_o = gp_o & p_i[i];
      end
   end

   // Bit carries inside the group, starting from the group carry-in.
   always_comb begin
      logic c;
      c   = ci_i;
      s_o = '0;
      for (int unsigned i = 0; i < GROUP; i++) begin
         s_o[i] = p_i[i] ^ c;
         c      = g_i[i] | (p_i[i] & c);
      end
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshake on both sides.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready combinational)
//   a, b, cin, mode      : operands, carry in (ignored for sub), 0=add 1=sub
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : registered result, carry out, signed overflow
// Optional build macro: CLA_OVF_EN enables signed-overflow detection;
// without it ovf is tied to 0 and the MSB capture registers are dropped.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH_DEF,
   parameter int unsigned GROUP = CLA_GROUP_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NGRP = WIDTH / GROUP;

   if ((GROUP == 0) || ((WIDTH % GROUP) != 0)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
   end

   // Handshake
   logic s1_ready, s2_ready, in_fire, s1_adv;

   // Stage 1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
   logic             c0_q, c0_d;

   // Stage 2 registers
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   // Lookahead network
   logic [WIDTH-1:0] bb;
   logic [NGRP-1:0]  gp_c, gg_c;
   logic [NGRP:0]    gc_c;
   logic [WIDTH-1:0] sum_c;

   assign s2_ready = !s2_valid_q || out_ready;
   assign s1_ready = !s1_valid_q || s2_ready;
   assign in_ready = s1_ready;
   assign in_fire  = in_valid && s1_ready;
   assign s1_adv   = s1_valid_q && s2_ready;

   // Subtraction is a + ~b + 1.
   assign bb = (mode == MODE_SUB) ? ~b : b;

   // Stage 1 next state: bitwise propagate/generate.
   always_comb begin
      s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
      p_d        = p_q;
      g_d        = g_q;
      c0_d       = c0_q;
      if (in_fire) begin
         p_d  = a ^ bb;
         g_d  = a & bb;
         c0_d = (mode == MODE_SUB) ? 1'b1 : cin;
      end
   end

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .p_i  (p_q[k*GROUP +: GROUP]),
         .g_i  (g_q[k*GROUP +: GROUP]),
         .ci_i (gc_c[k]),
         .gp_o (gp_c[k]),
         .gg_o (gg_c[k]),
         .s_o  (sum_c[k*GROUP +: GROUP])
      );
   end

   // Flattened group carries: C(k+1) = Gk | Pk.G(k-1) | ... | Pk..P0.c0,
   // a sum of products rather than a ripple through earlier group carries.
   always_comb begin
      logic acc, pp;
      gc_c    = '0;
      gc_c[0] = c0_q;
      for (int k = 0; k < int'(NGRP); k++) begin
         acc = gg_c[k];
         pp  = gp_c[k];
         for (int j = k; j > 0; j--) begin
            acc = acc | (pp & gg_c[j-1]);
            pp  = pp & gp_c[j-1];
         end
         gc_c[k+1] = acc | (pp & c0_q);
      end
   end

   // Stage 2 next state.
   always_comb begin
      s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
      sum_d      = sum_q;
      cout_d     = cout_q;
      if (s1_adv) begin
         sum_d  = sum_c;
         cout_d = gc_c[NGRP];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         p_q        <= '0;
         g_q        <= '0;
         c0_q       <= 1'b0;
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         p_q        <= p_d;
         g_q        <= g_d;
         c0_q       <= c0_d;
         s2_valid_q <= s2_valid_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
      end
   end

`ifdef CLA_OVF_EN
   // Operand MSBs travel with stage 1 so stage 2 can flag signed overflow.
   logic amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;

   always_comb begin
      amsb_d = amsb_q;
      bmsb_d = bmsb_q;
      ovf_d  = ovf_q;
      if (in_fire) begin
         amsb_d = a[WIDTH-1];
         bmsb_d = bb[WIDTH-1];
      end
      if (s1_adv) begin
         ovf_d = (amsb_q == bmsb_q) && (sum_c[WIDTH-1] != amsb_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         amsb_q <= 1'b0;
         bmsb_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         amsb_q <= amsb_d;
         bmsb_q <= bmsb_d;
         ovf_q  <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
